// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-FF synchronizer, debounce FSM,
//               press/release/long-press strobes and an 8-bit press counter.
//               Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int c_db_cnt   = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int c_long_cnt = (CLK_FREQ / 1000) * LONG_MS;
    localparam int c_db_w     = (c_db_cnt > 1) ? $clog2(c_db_cnt) : 1;
    // One extra code so the hold counter can park above the strobe point.
    localparam int c_long_w   = $clog2(c_long_cnt + 1);

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(c_db_cnt - 1);
    localparam logic [c_long_w-1:0] c_long_last = c_long_w'(c_long_cnt - 1);
    localparam logic [c_long_w-1:0] c_long_sat  = c_long_w'(c_long_cnt);
    localparam logic                c_pin_idle  = (ACTIVE_LOW != 0);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_press_chk = 2'd1;
    localparam logic [1:0] c_st_pressed   = 2'd2;
    localparam logic [1:0] c_st_rel_chk   = 2'd3;

    if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_bad_cfg
        $error("btn_debounce: invalid timing parameters");
    end

    logic                r_sync1;
    logic                r_sync2;
    logic                w_act;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_db_w-1:0]   r_db_cnt;
    logic [c_db_w-1:0]   w_db_next;
    logic [c_long_w-1:0] r_long_cnt;
    logic                w_accept_press;
    logic                w_accept_release;
    logic                w_held;
    logic                w_rep_fire;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic [7:0]          r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_pin_idle;
            r_sync2 <= c_pin_idle;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_act  = r_sync2 ^ c_pin_idle;
    assign w_held = (r_state == c_st_pressed) || (r_state == c_st_rel_chk);

    always_comb begin
        w_state_next     = r_state;
        w_db_next        = r_db_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_db_next = '0;
                if (w_act) w_state_next = c_st_press_chk;
            end
            c_st_press_chk: begin
                if (!w_act) begin
                    w_state_next = c_st_idle;
                    w_db_next    = '0;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_next   = c_st_pressed;
                    w_db_next      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_db_next = r_db_cnt + c_db_w'(1);
                end
            end
            c_st_pressed: begin
                w_db_next = '0;
                if (!w_act) w_state_next = c_st_rel_chk;
            end
            c_st_rel_chk: begin
                if (w_act) begin
                    w_state_next = c_st_pressed;
                    w_db_next    = '0;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_next     = c_st_idle;
                    w_db_next        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_db_next = r_db_cnt + c_db_w'(1);
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_db_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_db_cnt <= w_db_next;
        end
    end

    // Hold timer runs across release bounces and saturates so long_press fires once per hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else if (!w_held || w_accept_release) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            if (r_long_cnt != c_long_sat) r_long_cnt <= r_long_cnt + c_long_w'(1);
            r_long <= (r_long_cnt == c_long_last);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_rep_cnt = (CLK_FREQ / 1000) * REPEAT_MS;
    localparam int c_rep_w   = (c_rep_cnt > 1) ? $clog2(c_rep_cnt) : 1;
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(c_rep_cnt - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               w_rep_run;

    // Repeat interval starts only once the long-press strobe has gone out.
    assign w_rep_run  = w_held && !w_accept_release && (r_long_cnt == c_long_sat);
    assign w_rep_fire = w_rep_run && (r_rep_cnt == c_rep_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (!w_rep_run || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= 8'h00;
        end else begin
            r_press   <= w_accept_press | w_rep_fire;
            r_release <= w_accept_release;
            if (w_accept_press) r_level <= 1'b1;
            else if (w_accept_release) r_level <= 1'b0;
            if (w_accept_press || w_rep_fire) r_count <= r_count + 8'd1;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign long_press  = r_long;
    assign press_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Directed self-checking bench for btn_debounce (DB=1000,
//               LONG=5000, REP=2000 cycles) plus a fast instance for wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_in  = 1'b1;
    logic       btn_in2 = 1'b1;
    logic       btn_level, btn_press, btn_release, long_press;
    logic [7:0] press_count;
    logic       level2, press2, release2, long2;
    logic [7:0] count2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_count = 0;
    int n_press = 0, n_release = 0, n_long = 0, n_dbl = 0, n_both = 0;
    int t_press = 0, t_release = 0, t_long = 0;
    logic p_press = 1'b0, p_release = 1'b0, p_long = 1'b0;

    btn_debounce #(
        .CLK_FREQ(1_000_000), .DEBOUNCE_MS(1), .LONG_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .long_press(long_press),
        .press_count(press_count)
    );

    // DB=4, LONG=20, REP=8 cycles: keeps 256 presses short
    btn_debounce #(
        .CLK_FREQ(4000), .DEBOUNCE_MS(1), .LONG_MS(5), .REPEAT_MS(2), .ACTIVE_LOW(1)
    ) dut_fast (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in2), .btn_level(level2),
        .btn_press(press2), .btn_release(release2), .long_press(long2),
        .press_count(count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (btn_press)   begin n_press++;   t_press   = cyc; end
        if (btn_release) begin n_release++; t_release = cyc; end
        if (long_press)  begin n_long++;    t_long    = cyc; end
        if ((btn_press && p_press) || (btn_release && p_release) || (long_press && p_long)) n_dbl++;
        if (btn_press && btn_release) n_both++;
        p_press   = btn_press;
        p_release = btn_release;
        p_long    = long_press;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (btn_level !== 1'b0)      begin errors++; $display("FAIL reset_level: got %b expected 0", btn_level); end
        checks++; if (btn_press !== 1'b0)      begin errors++; $display("FAIL reset_press: got %b expected 0", btn_press); end
        checks++; if (btn_release !== 1'b0)    begin errors++; $display("FAIL reset_release: got %b expected 0", btn_release); end
        checks++; if (long_press !== 1'b0)     begin errors++; $display("FAIL reset_long: got %b expected 0", long_press); end
        checks++; if (press_count !== 8'h00)   begin errors++; $display("FAIL reset_count: got %0d expected 0", press_count); end
        checks++; if (count2 !== 8'h00)        begin errors++; $display("FAIL reset_count_fast: got %0d expected 0", count2); end
        rst_n = 1'b1;
        step(5);
    endtask

    task automatic test_clean_press;
        int np0, nr0, t0, k;
        np0 = n_press; nr0 = n_release;
        btn_in = 1'b0; t0 = cyc; k = 0;
        while (n_press == np0 && k < 1500) begin step(1); k++; end
        exp_count++;
        checks++; if (n_press != np0 + 1) begin errors++; $display("FAIL clean_press_seen: got %0d strobes expected 1", n_press - np0); end
        checks++; if (t_press - t0 < 1001 || t_press - t0 > 1003) begin errors++; $display("FAIL clean_press_latency: got %0d expected 1001..1003", t_press - t0); end
        step(1);
        checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL clean_level_high: got %b expected 1", btn_level); end
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL clean_count: got %0d expected %0d", press_count, exp_count); end
        step(3000 - (cyc - t0));
        checks++; if (n_press != np0 + 1 || n_release != nr0) begin errors++; $display("FAIL clean_hold_strobes: got press %0d release %0d expected 1 0", n_press - np0, n_release - nr0); end
        btn_in = 1'b1; t0 = cyc; k = 0;
        while (n_release == nr0 && k < 1500) begin step(1); k++; end
        checks++; if (n_release != nr0 + 1) begin errors++; $display("FAIL clean_release_seen: got %0d strobes expected 1", n_release - nr0); end
        checks++; if (t_release - t0 < 1001 || t_release - t0 > 1003) begin errors++; $display("FAIL clean_release_latency: got %0d expected 1001..1003", t_release - t0); end
        step(1);
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL clean_level_low: got %b expected 0", btn_level); end
        step(50);
    endtask

    task automatic test_bounce;
        int np0, nr0, t0, k;
        np0 = n_press; nr0 = n_release;
        for (int i = 0; i < 8; i++) begin btn_in = ~btn_in; step(100); end
        btn_in = 1'b0; t0 = cyc; k = 0;
        while (n_press == np0 && k < 1500) begin step(1); k++; end
        exp_count++;
        checks++; if (n_press != np0 + 1) begin errors++; $display("FAIL bounce_press_once: got %0d strobes expected 1", n_press - np0); end
        checks++; if (t_press - t0 < 1001 || t_press - t0 > 1003) begin errors++; $display("FAIL bounce_press_latency: got %0d expected 1001..1003", t_press - t0); end
        checks++; if (n_release != nr0) begin errors++; $display("FAIL bounce_no_release: got %0d strobes expected 0", n_release - nr0); end
        step(200);
        for (int i = 0; i < 8; i++) begin btn_in = ~btn_in; step(100); end
        btn_in = 1'b1; t0 = cyc; k = 0;
        while (n_release == nr0 && k < 1500) begin step(1); k++; end
        checks++; if (n_release != nr0 + 1) begin errors++; $display("FAIL bounce_release_once: got %0d strobes expected 1", n_release - nr0); end
        checks++; if (t_release - t0 < 1001 || t_release - t0 > 1003) begin errors++; $display("FAIL bounce_release_latency: got %0d expected 1001..1003", t_release - t0); end
        step(1);
        checks++; if (n_press != np0 + 1 || press_count !== 8'(exp_count)) begin errors++; $display("FAIL bounce_release_no_press: got strobes %0d count %0d expected 1 %0d", n_press - np0, press_count, exp_count); end
        step(50);
    endtask

    task automatic test_glitch;
        int np0, nr0;
        np0 = n_press; nr0 = n_release;
        btn_in = 1'b0;
        step(999);
        btn_in = 1'b1;
        step(1200);
        checks++; if (n_press != np0 || n_release != nr0) begin errors++; $display("FAIL glitch_strobes: got press %0d release %0d expected 0 0", n_press - np0, n_release - nr0); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch_level: got %b expected 0", btn_level); end
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", press_count, exp_count); end
    endtask

    task automatic test_long_press;
        int np0, nr0, nl0, t0, tp, k;
        np0 = n_press; nr0 = n_release; nl0 = n_long;
        btn_in = 1'b0; t0 = cyc; k = 0;
        while (n_press == np0 && k < 1500) begin step(1); k++; end
        tp = t_press;
        step(8000 - (cyc - t0));
        btn_in = 1'b1; k = 0;
        while (n_release == nr0 && k < 1500) begin step(1); k++; end
        checks++; if (n_release != nr0 + 1) begin errors++; $display("FAIL long_release_seen: got %0d strobes expected 1", n_release - nr0); end
        checks++; if (n_long != nl0 + 1) begin errors++; $display("FAIL long_once: got %0d strobes expected 1", n_long - nl0); end
        checks++; if (t_long - tp < 4999 || t_long - tp > 5001) begin errors++; $display("FAIL long_delay: got %0d expected 4999..5001", t_long - tp); end
`ifdef BTN_AUTOREPEAT_EN
        exp_count += 2;
        checks++; if (n_press != np0 + 2) begin errors++; $display("FAIL long_repeat_strobes: got %0d expected 2", n_press - np0); end
        checks++; if (t_press - tp < 6999 || t_press - tp > 7001) begin errors++; $display("FAIL long_repeat_delay: got %0d expected 6999..7001", t_press - tp); end
`else
        exp_count += 1;
        checks++; if (n_press != np0 + 1) begin errors++; $display("FAIL long_single_press: got %0d expected 1", n_press - np0); end
`endif
        checks++; if (press_count !== 8'(exp_count)) begin errors++; $display("FAIL long_count: got %0d expected %0d", press_count, exp_count); end
        step(50);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 255; i++) begin
            btn_in2 = 1'b0; step(12);
            btn_in2 = 1'b1; step(12);
        end
        checks++; if (count2 !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", count2); end
        btn_in2 = 1'b0; step(12);
        checks++; if (level2 !== 1'b1) begin errors++; $display("FAIL wrap_level: got %b expected 1", level2); end
        btn_in2 = 1'b1; step(12);
        checks++; if (count2 !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", count2); end
    endtask

    task automatic test_reset_mid_hold;
        int np0, nr0, t0, k;
        np0 = n_press; nr0 = n_release;
        btn_in = 1'b0; k = 0;
        while (n_press == np0 && k < 1500) begin step(1); k++; end
        step(500);
        checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL midhold_level_before: got %b expected 1", btn_level); end
        rst_n = 1'b0;
        #1;
        checks++; if (btn_level !== 1'b0 || press_count !== 8'h00 || long_press !== 1'b0 || btn_press !== 1'b0) begin
            errors++; $display("FAIL midhold_async_clear: got level %b count %0d long %b press %b expected 0 0 0 0", btn_level, press_count, long_press, btn_press);
        end
        step(3);
        checks++; if (n_release != nr0) begin errors++; $display("FAIL midhold_no_release: got %0d strobes expected 0", n_release - nr0); end
        np0 = n_press;
        rst_n = 1'b1; t0 = cyc; k = 0;
        while (n_press == np0 && k < 1500) begin step(1); k++; end
        checks++; if (n_press != np0 + 1) begin errors++; $display("FAIL midhold_repress_seen: got %0d strobes expected 1", n_press - np0); end
        checks++; if (t_press - t0 < 1000 || t_press - t0 > 1004) begin errors++; $display("FAIL midhold_repress_latency: got %0d expected 1000..1004", t_press - t0); end
        step(1);
        checks++; if (press_count !== 8'd1 || btn_level !== 1'b1) begin errors++; $display("FAIL midhold_repress_state: got count %0d level %b expected 1 1", press_count, btn_level); end
        btn_in = 1'b1; k = 0;
        nr0 = n_release;
        while (n_release == nr0 && k < 1500) begin step(1); k++; end
        checks++; if (n_release != nr0 + 1) begin errors++; $display("FAIL midhold_final_release: got %0d strobes expected 1", n_release - nr0); end
    endtask

    task automatic test_strobe_rules;
        checks++; if (n_dbl != 0)  begin errors++; $display("FAIL strobe_width: got %0d wide strobes expected 0", n_dbl); end
        checks++; if (n_both != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", n_both); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_wrap();
        test_reset_mid_hold();
        test_strobe_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Input-side counterpart to the LED output drivers: conditions a raw push-button/DIP input from a board pin into clean, glitch-free status for the fabric.
- 2-FF synchronizer, counter-based debounce FSM, single-cycle press/release strobes, long-press detection, 8-bit press counter.
- Sits between a board pin and LED/control logic, in the same clock domain as the blink modules.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
DEBOUNCE_MS, 20, stable time in ms required to accept a level change (>=1)
LONG_MS, 1000, hold time in ms from press acceptance to long-press strobe (must be > DEBOUNCE_MS)
REPEAT_MS, 200, auto-repeat interval in ms (used only with BTN_AUTOREPEAT_EN)
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
btn_in  input  1  raw asynchronous button pin
btn_level  output  1  debounced level, 1 = pressed
btn_press  output  1  one-cycle strobe on accepted press
btn_release  output  1  one-cycle strobe on accepted release
long_press  output  1  one-cycle strobe after LONG_MS continuous hold
press_count  output  8  number of accepted presses, wraps 255->0

Behaviour:
- Reset domain: single clock clk; reset is asynchronous, active-low (rst_n). Asserting rst_n immediately forces all state and outputs to their reset values.
- Derived constants:
  - DB_CNT = (CLK_FREQ/1000)*DEBOUNCE_MS
  - LONG_CNT = (CLK_FREQ/1000)*LONG_MS
  - REP_CNT = (CLK_FREQ/1000)*REPEAT_MS
  - Counter widths via $clog2 of each constant.
- Synchronizer:
  - 2 flops; reset to the inactive pin level (1 if ACTIVE_LOW, else 0).
  - Normalized signal act = sync2 XOR ACTIVE_LOW, so act = 1 means pressed.
- Output reset values: btn_level=0, btn_press=0, btn_release=0, long_press=0, press_count=0. FSM resets to IDLE; all counters reset to 0.
- FSM (db_cnt, long_cnt):
  - IDLE: db_cnt=0, long_cnt=0. act=1 -> PRESS_CHK.
  - PRESS_CHK: db_cnt increments while act=1.
    - act=0 -> IDLE (db_cnt cleared).
    - db_cnt==DB_CNT-1 with act=1 -> PRESSED; btn_level<=1; btn_press pulses for 1 cycle; press_count+1.
  - PRESSED: db_cnt=0; long_cnt increments, saturating.
    - long_cnt reaches LONG_CNT-1 -> long_press pulses once per hold.
    - act=0 -> REL_CHK.
  - REL_CHK: db_cnt increments while act=0; long_cnt keeps running.
    - act=1 -> PRESSED (bounce; no strobe; db_cnt cleared).
    - db_cnt==DB_CNT-1 with act=0 -> IDLE; btn_level<=0; btn_release pulses for 1 cycle; long_cnt cleared.
- Latency: btn_press asserts exactly 2 + DB_CNT clk cycles after a clean edge on btn_in, ±1 cycle for sampling. Release latency is identical.
- Strobes are registered outputs, never high two consecutive cycles. btn_press and btn_release are never high in the same cycle.
- Any glitch shorter than DB_CNT cycles produces no output change.
- press_count wraps 8'hFF -> 8'h00 with no flag.
- Reset mid-hold: outputs return to 0 immediately, with no btn_release strobe. After reset deassertion, a still-held button is re-accepted as a new press after the debounce time.

Optional Feature:
Macro: BTN_AUTOREPEAT_EN
- Defined:
  - After the long_press strobe, while in PRESSED or REL_CHK, a repeat counter runs. btn_press re-strobes and press_count increments every REP_CNT cycles.
  - The first repeat occurs REP_CNT cycles after long_press.
  - The repeat counter clears on IDLE entry.
- Undefined: no repeat logic is synthesized; exactly one btn_press per accepted press.

Test Plan:
Test parameter set for all scenarios: CLK_FREQ=1_000_000, DEBOUNCE_MS=1 (DB_CNT=1000), LONG_MS=5 (LONG_CNT=5000), REPEAT_MS=2 (REP_CNT=2000), ACTIVE_LOW=1.
- Clean press: btn_in 1->0 held 3000 cycles -> btn_press pulses once at ~1002 cycles; btn_level=1; press_count=1. Release -> btn_release pulses ~1002 cycles later; btn_level=0.
- Bounce: btn_in toggles every 100 cycles 8 times, then holds 0 -> exactly one btn_press, 1002 cycles after the last toggle; no release strobe.
- Glitch: 999-cycle low pulse on btn_in -> no strobes; btn_level stays 0; press_count unchanged.
- Long press: hold 0 for 8000 cycles -> long_press pulses once, 5000 cycles after btn_press. With macro: btn_press also re-pulses at +2000 cycles, press_count=2. Without macro: press_count=1.
- Wrap + reset: 256 clean presses -> press_count=0. Press, then assert rst_n low mid-hold -> all outputs 0 with no btn_release; release rst_n with btn held -> new btn_press after ~1002 cycles.
